// File: rtl/user_cmd_arbiter.sv
// rtl/user_cmd_arbiter.sv - round-robin user-command arbiter with bank-ready gating and read-tag steering
// Optional build macro: ARB_ROW_HIT_PRIORITY_EN (open-row hit priority with per-requester starvation override).
// Command layout (LSB first): [0] r_w (1 = read, 0 = write), [2:1] bank_addr, [ROW_W+2:3] row_addr, rest opaque.
module user_cmd_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int RD_TAG_DEPTH = 16,
    parameter int CMD_W        = 32,
    parameter int DATA_W       = 64,
    parameter int ROW_W        = 13
) (
    input  logic                              clk,
    input  logic                              power_on_rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*CMD_W-1:0]          req_cmd,
    input  logic [NUM_REQ*DATA_W-1:0]         req_wdata,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [3:0]                        ba_cmd_pm,
    output logic [CMD_W-1:0]                  command,
    output logic [DATA_W-1:0]                 write_data,
    output logic                              valid,
    input  logic [DATA_W-1:0]                 read_data,
    input  logic                              read_data_valid,
    output logic [DATA_W-1:0]                 rd_data,
    output logic [NUM_REQ-1:0]                rd_valid,
    output logic [$clog2(RD_TAG_DEPTH):0]     rd_tag_cnt,
    output logic                              err_orphan
);

    localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW       = $clog2(RD_TAG_DEPTH);
    localparam int CNT_W    = AW + 1;
    localparam int RW_BIT   = 0;
    localparam int BANK_LSB = 1;
    localparam int ROW_LSB  = 3;

    // Per-requester decoded fields and eligibility
    logic [CMD_W-1:0]   cmd_a  [NUM_REQ];
    logic [1:0]         bank_a [NUM_REQ];
    logic [NUM_REQ-1:0] is_rd;
    logic [NUM_REQ-1:0] elig;
    logic               tag_block;

    // Arbitration result
    logic [IDW:0]       pick;
    logic               grant_vld;
    logic [IDW-1:0]     win;
    logic [CMD_W-1:0]   win_cmd;
    logic [DATA_W-1:0]  win_wd;
    logic               win_rd;

    // Issue / pointer state
    logic [IDW-1:0]     ptr_q;
    logic [CMD_W-1:0]   command_q;
    logic [DATA_W-1:0]  write_data_q;
    logic               valid_q;

    // Tag FIFO and read-return state
    logic [IDW-1:0]     tag_mem [RD_TAG_DEPTH];
    logic [AW-1:0]      tag_wr_q;
    logic [AW-1:0]      tag_rd_q;
    logic [CNT_W-1:0]   tag_cnt_q;
    logic               tag_push;
    logic               tag_pop;
    logic               orphan;
    logic [NUM_REQ-1:0] rd_valid_d;
    logic [NUM_REQ-1:0] rd_valid_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic               err_q;

    // First set bit of mask at or after start, wrapping; MSB of result flags "found"
    function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] mask, input logic [IDW-1:0] start);
        logic [IDW:0] r;
        int           idx;
        r = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(start) + k) % NUM_REQ;
            if (!r[IDW] && mask[idx]) r = {1'b1, IDW'(idx)};
        end
        return r;
    endfunction

    // Decode each request and decide eligibility; a same-cycle pop frees a slot for a read
    always_comb begin
        tag_block = (tag_cnt_q == CNT_W'(RD_TAG_DEPTH)) && !read_data_valid;
        is_rd     = '0;
        elig      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cmd_a[i]  = req_cmd[i*CMD_W +: CMD_W];
            bank_a[i] = cmd_a[i][BANK_LSB +: 2];
            is_rd[i]  = cmd_a[i][RW_BIT];
            elig[i]   = req_valid[i] && ba_cmd_pm[bank_a[i]] && (!is_rd[i] || !tag_block);
        end
    end

`ifdef ARB_ROW_HIT_PRIORITY_EN
    logic [ROW_W-1:0]   row_a     [NUM_REQ];
    logic [ROW_W-1:0]   open_row_q [4];
    logic [3:0]         open_vld_q;
    logic [3:0]         starve_q  [NUM_REQ];
    logic [NUM_REQ-1:0] hit;
    logic [NUM_REQ-1:0] starved;
    logic [1:0]         win_bank;
    logic [ROW_W-1:0]   win_row;

    // Row-hit and starvation masks, both restricted to eligible requesters
    always_comb begin
        hit     = '0;
        starved = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            row_a[i]   = cmd_a[i][ROW_LSB +: ROW_W];
            hit[i]     = elig[i] && open_vld_q[bank_a[i]] && (open_row_q[bank_a[i]] == row_a[i]);
            starved[i] = elig[i] && (starve_q[i] == 4'd15);
        end
    end

    // Bank/row of the winner, for the open-row table
    always_comb begin
        win_bank = '0;
        win_row  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == win) begin
                win_bank = bank_a[i];
                win_row  = row_a[i];
            end
        end
    end

    // Track the last issued row per bank and age eligible-but-denied requesters
    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            open_vld_q <= '0;
            for (int b = 0; b < 4; b++) open_row_q[b] <= '0;
            for (int i = 0; i < NUM_REQ; i++) starve_q[i] <= '0;
        end else begin
            if (grant_vld) begin
                open_row_q[win_bank] <= win_row;
                open_vld_q[win_bank] <= 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_vld && (win == IDW'(i))) starve_q[i] <= '0;
                else if (elig[i] && (starve_q[i] != 4'd15)) starve_q[i] <= starve_q[i] + 4'd1;
            end
        end
    end
`endif

    // Choose the winner: starved first, then row hits, then plain round-robin
    always_comb begin
`ifdef ARB_ROW_HIT_PRIORITY_EN
        if (|starved)  pick = rr_pick(starved, ptr_q);
        else if (|hit) pick = rr_pick(hit, ptr_q);
        else           pick = rr_pick(elig, ptr_q);
`else
        pick = rr_pick(elig, ptr_q);
`endif
        grant_vld = pick[IDW] && power_on_rst_n;
        win       = pick[IDW-1:0];
    end

    // Mux the winner's command/data and drive the one-hot accept strobe
    always_comb begin
        win_cmd   = '0;
        win_wd    = '0;
        win_rd    = 1'b0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == win) begin
                win_cmd = cmd_a[i];
                win_wd  = req_wdata[i*DATA_W +: DATA_W];
                win_rd  = is_rd[i];
            end
        end
        if (grant_vld) req_ready[win] = 1'b1;
    end

    // Register the issued command and advance the round-robin pointer past the winner
    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            ptr_q        <= '0;
            command_q    <= '0;
            write_data_q <= '0;
            valid_q      <= 1'b0;
        end else if (grant_vld) begin
            ptr_q        <= (win == IDW'(NUM_REQ-1)) ? '0 : win + IDW'(1);
            command_q    <= win_cmd;
            write_data_q <= win_rd ? '0 : win_wd;
            valid_q      <= 1'b1;
        end else begin
            command_q    <= '0;
            valid_q      <= 1'b0;
        end
    end

    // Tag FIFO control and one-hot steering of the returning read
    always_comb begin
        tag_push   = grant_vld && win_rd;
        tag_pop    = read_data_valid && (tag_cnt_q != '0);
        orphan     = read_data_valid && (tag_cnt_q == '0);
        rd_valid_d = '0;
        if (tag_pop) rd_valid_d[tag_mem[tag_rd_q]] = 1'b1;
    end

    // Tag storage; a push into a full FIFO only happens alongside a pop of the same slot
    always_ff @(posedge clk) begin
        if (tag_push) tag_mem[tag_wr_q] <= win;
    end

    // Tag pointers, occupancy, read return and sticky orphan flag
    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            tag_cnt_q  <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            if (tag_push) tag_wr_q <= tag_wr_q + AW'(1);
            if (tag_pop)  tag_rd_q <= tag_rd_q + AW'(1);
            if (tag_push && !tag_pop)      tag_cnt_q <= tag_cnt_q + CNT_W'(1);
            else if (tag_pop && !tag_push) tag_cnt_q <= tag_cnt_q - CNT_W'(1);
            rd_valid_q <= rd_valid_d;
            if (tag_pop) rd_data_q <= read_data;
            if (orphan)  err_q <= 1'b1;
        end
    end

    assign command    = command_q;
    assign write_data = write_data_q;
    assign valid      = valid_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign rd_tag_cnt = tag_cnt_q;
    assign err_orphan = err_q;

endmodule

// File: tb/tb_user_cmd_arbiter.sv
// tb/tb_user_cmd_arbiter.sv - self-checking bench for user_cmd_arbiter
module tb_user_cmd_arbiter;

    localparam int N     = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 32;
    localparam int DW    = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [CW-1:0]   cmds [N];
    logic [DW-1:0]   wds  [N];
    logic [N*CW-1:0] req_cmd;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [3:0]      ba_cmd_pm;
    logic [CW-1:0]   command;
    logic [DW-1:0]   write_data;
    logic            valid;
    logic [DW-1:0]   read_data;
    logic            read_data_valid;
    logic [DW-1:0]   rd_data;
    logic [N-1:0]    rd_valid;
    logic [4:0]      rd_tag_cnt;
    logic            err_orphan;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b1;

    always #5 clk = ~clk;

    always_comb begin
        req_cmd   = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            req_cmd[i*CW +: CW]   = cmds[i];
            req_wdata[i*DW +: DW] = wds[i];
        end
    end

    user_cmd_arbiter #(.NUM_REQ(N), .RD_TAG_DEPTH(DEPTH), .CMD_W(CW), .DATA_W(DW), .ROW_W(13)) dut (
        .clk(clk), .power_on_rst_n(rst_n),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_wdata(req_wdata), .req_ready(req_ready),
        .ba_cmd_pm(ba_cmd_pm), .command(command), .write_data(write_data), .valid(valid),
        .read_data(read_data), .read_data_valid(read_data_valid),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_tag_cnt(rd_tag_cnt), .err_orphan(err_orphan)
    );

    function automatic logic [CW-1:0] mk(input logic rd, input logic [1:0] bank, input logic [12:0] row, input logic [15:0] ex);
        return {ex, row, bank, rd};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: requester queue of outstanding read tags and expected registered outputs
    int            m_ptr;
    int            tagq [$];
    logic [CW-1:0] m_cmd;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] m_rdd;
    logic [N-1:0]  m_rdv;
    logic          m_valid;
    logic          m_err;

    function automatic int model_winner();
        int i;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (req_valid[i] && ba_cmd_pm[cmds[i][2:1]] &&
                (!cmds[i][0] || tagq.size() < DEPTH || read_data_valid)) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            m_ptr = 0; tagq.delete(); m_cmd = '0; m_wd = '0; m_rdd = '0;
            m_rdv = '0; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            w = model_winner();
            m_rdv = '0;
            if (read_data_valid) begin
                if (tagq.size() > 0) begin
                    m_rdv = N'(1) << tagq[0];
                    m_rdd = read_data;
                    void'(tagq.pop_front());
                end else begin
                    m_err = 1'b1;
                end
            end
            if (w >= 0) begin
                m_cmd   = cmds[w];
                m_wd    = cmds[w][0] ? '0 : wds[w];
                m_valid = 1'b1;
                m_ptr   = (w + 1) % N;
                if (cmds[w][0]) tagq.push_back(w);
            end else begin
                m_cmd   = '0;
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int w;
        if (rst_n && chk_en) begin
            w = model_winner();
            chk("m_req_ready", req_ready, (w < 0) ? '0 : (DW'(1) << w));
            chk("m_valid", valid, m_valid);
            chk("m_command", command, m_cmd);
            chk("m_write_data", write_data, m_wd);
            chk("m_rd_valid", rd_valid, m_rdv);
            chk("m_rd_data", rd_data, m_rdd);
            chk("m_rd_tag_cnt", rd_tag_cnt, tagq.size());
            chk("m_err_orphan", err_orphan, m_err);
        end
    end

    // Present one request and hold it until accepted; leaves time at posedge+1
    task automatic issue_one(input int i, input logic [CW-1:0] c, input logic [DW-1:0] d);
        bit got = 1'b0;
        cmds[i] = c; wds[i] = d; req_valid[i] = 1'b1;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        chk("issue_accept", got, 1'b1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [CW-1:0] c2;
        logic [DW-1:0] dret [3];
        logic [N-1:0]  oh   [3];
        req_valid = '0; ba_cmd_pm = '0; read_data = '0; read_data_valid = 1'b0;
        for (int i = 0; i < N; i++) begin cmds[i] = '0; wds[i] = '0; end
        repeat (2) @(posedge clk); #1;
        chk("rst_valid", valid, 0);
        chk("rst_command", command, 0);
        chk("rst_rd_tag_cnt", rd_tag_cnt, 0);
        chk("rst_err", err_orphan, 0);
        rst_n = 1'b1;

        // All four write bank 0 back to back
        ba_cmd_pm = 4'hF;
        for (int i = 0; i < N; i++) begin
            cmds[i] = mk(1'b0, 2'd0, 13'd0, 16'(16'h100 + i));
            wds[i]  = 64'h1111_0000_0000_0000 + 64'(i * 3 + 7);
        end
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t1_grant", req_ready, 4'b0001 << (k % 4));
            if (k > 0) begin
                chk("t1_valid", valid, 1);
                chk("t1_wdata", write_data, wds[(k - 1) % 4]);
            end
        end
        @(posedge clk); #1;
        req_valid = '0;

        // Bank not ready blocks the read until its flag rises
        ba_cmd_pm = 4'b1011;
        c2 = mk(1'b1, 2'd2, 13'd0, 16'h0B0B);
        cmds[1] = c2; req_valid[1] = 1'b1;
        @(negedge clk); chk("t2_blocked", req_ready, 0);
        @(negedge clk); chk("t2_blocked2", req_ready, 0);
        @(posedge clk); #1; ba_cmd_pm = 4'hF;
        @(negedge clk); chk("t2_grant", req_ready, 4'b0010);
        @(posedge clk); #1; req_valid[1] = 1'b0;
        @(negedge clk);
        chk("t2_valid", valid, 1);
        chk("t2_command", command, c2);
        chk("t2_wdata_read", write_data, 0);
        @(posedge clk); #1; read_data_valid = 1'b1; read_data = 64'hD0D0;
        @(posedge clk); #1; read_data_valid = 1'b0;
        @(negedge clk);
        chk("t2_rd_valid", rd_valid, 4'b0010);
        chk("t2_rd_data", rd_data, 64'hD0D0);
        chk("t2_cnt", rd_tag_cnt, 0);

        // In-order read returns steer to 2, 0, 3
        @(posedge clk); #1;
        issue_one(2, mk(1'b1, 2'd0, 13'd0, 16'h0202), 64'hFFFF);
        issue_one(0, mk(1'b1, 2'd0, 13'd0, 16'h0000), 64'hFFFF);
        issue_one(3, mk(1'b1, 2'd0, 13'd0, 16'h0303), 64'hFFFF);
        @(negedge clk); chk("t3_cnt3", rd_tag_cnt, 3);
        dret[0] = 64'hDA7A_0000_0000_0002; dret[1] = 64'hDA7A_0000_0000_0000; dret[2] = 64'hDA7A_0000_0000_0003;
        oh[0] = 4'b0100; oh[1] = 4'b0001; oh[2] = 4'b1000;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1; read_data_valid = 1'b1; read_data = dret[j];
            @(posedge clk); #1; read_data_valid = 1'b0;
            @(negedge clk);
            chk("t3_rd_valid", rd_valid, oh[j]);
            chk("t3_rd_data", rd_data, dret[j]);
        end
        chk("t3_cnt0", rd_tag_cnt, 0);

        // Full tag FIFO: writes pass, reads wait, push+pop keeps the count
        @(posedge clk); #1;
        for (int j = 0; j < DEPTH; j++) issue_one(0, mk(1'b1, 2'd0, 13'd0, 16'(j)), 64'h0);
        @(negedge clk); chk("t4_full", rd_tag_cnt, 16);
        @(posedge clk); #1;
        cmds[0] = mk(1'b1, 2'd0, 13'd0, 16'hEEEE);
        cmds[1] = mk(1'b0, 2'd0, 13'd0, 16'h1111); wds[1] = 64'h5555_AAAA;
        req_valid = 4'b0011;
        @(negedge clk); chk("t4_write_wins", req_ready, 4'b0010);
        @(posedge clk); #1; req_valid[1] = 1'b0;
        @(negedge clk); chk("t4_read_blocked", req_ready, 0);
        @(posedge clk); #1; read_data_valid = 1'b1; read_data = 64'hBEEF;
        @(negedge clk); chk("t4_read_with_pop", req_ready, 4'b0001);
        @(posedge clk); #1; read_data_valid = 1'b0; req_valid = '0;
        @(negedge clk);
        chk("t4_cnt_stays", rd_tag_cnt, 16);
        chk("t4_rd_valid", rd_valid, 4'b0001);
        @(posedge clk); #1; read_data_valid = 1'b1;
        repeat (16) @(posedge clk);
        #1; read_data_valid = 1'b0;
        @(negedge clk); chk("t4_drained", rd_tag_cnt, 0);

        // Orphan return, then reset with tags outstanding
        @(posedge clk); #1; read_data_valid = 1'b1; read_data = 64'h0BAD;
        @(posedge clk); #1; read_data_valid = 1'b0;
        @(negedge clk);
        chk("t5_no_rd_valid", rd_valid, 0);
        chk("t5_err", err_orphan, 1);
        repeat (3) @(negedge clk);
        chk("t5_err_sticky", err_orphan, 1);
        @(posedge clk); #1;
        for (int j = 0; j < 5; j++) issue_one(j % N, mk(1'b1, 2'd0, 13'd0, 16'(j)), 64'h0);
        @(negedge clk); chk("t5_cnt5", rd_tag_cnt, 5);
        @(posedge clk); #3; rst_n = 1'b0;
        #1;
        chk("t5_rst_cnt", rd_tag_cnt, 0);
        chk("t5_rst_err", err_orphan, 0);
        chk("t5_rst_valid", valid, 0);
        chk("t5_rst_command", command, 0);
        chk("t5_rst_wdata", write_data, 0);
        chk("t5_rst_rd_data", rd_data, 0);
        chk("t5_rst_rd_valid", rd_valid, 0);
        chk("t5_rst_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        @(negedge clk); chk("t5_after_rst_cnt", rd_tag_cnt, 0);

`ifdef ARB_ROW_HIT_PRIORITY_EN
        // Row-hit priority over round-robin, then starvation override after 15 denials
        chk_en = 1'b0;
        @(posedge clk); #1;
        issue_one(3, mk(1'b0, 2'd0, 13'h10, 16'h3333), 64'h3);
        cmds[0] = mk(1'b0, 2'd0, 13'h20, 16'h0000); wds[0] = 64'h00;
        cmds[1] = mk(1'b0, 2'd0, 13'h10, 16'h1111); wds[1] = 64'h11;
        req_valid = 4'b0011;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("rh_grant", req_ready, (k < 15) ? 4'b0010 : 4'b0001);
        end
        @(posedge clk); #1; req_valid = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/user_cmd_arbiter.md
Name: user_cmd_arbiter

Overview:
- Shares the single user-command port of the command scheduler among NUM_REQ requesters, e.g. a DMA engine, an image loader and a debug port.
- Arbitrates round-robin and only grants commands whose target bank is ready according to ba_cmd_pm.
- Forwards the write data alongside each command.
- Records the requester ID of every issued read in a tag FIFO, so in-order read_data returns are steered back to the originating requester.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- RD_TAG_DEPTH, 16: outstanding-read tag FIFO depth, power of 2.
- CMD_W, `USER_COMMAND_BITS: width of one command; fields follow usertype::user_command_type_t (r_w, bank_addr, row_addr, ...).
- DATA_W, `DQ_BITS*8: write/read data width.

Ports:
- clk  in  1: system clock.
- power_on_rst_n  in  1: asynchronous active-low reset.
- req_valid  in  NUM_REQ: request pending, one bit per requester.
- req_cmd  in  NUM_REQ*CMD_W: flattened commands; requester i occupies slice i.
- req_wdata  in  NUM_REQ*DATA_W: flattened write data.
- req_ready  out  NUM_REQ: one-hot accept strobe.
- ba_cmd_pm  in  4: per-bank "scheduler can accept a command" flags.
- command  out  CMD_W: command to the scheduler.
- write_data  out  DATA_W: write data to the scheduler.
- valid  out  1: command/write_data valid.
- read_data  in  DATA_W: read data from the scheduler.
- read_data_valid  in  1: read data strobe.
- rd_data  out  DATA_W: read data, broadcast to all requesters.
- rd_valid  out  NUM_REQ: one-hot read-return strobe.
- rd_tag_cnt  out  $clog2(RD_TAG_DEPTH)+1: number of outstanding reads.
- err_orphan  out  1: sticky flag; read data arrived with no outstanding tag.

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-low, on power_on_rst_n.
- Reset values: all outputs 0, round-robin pointer 0, tag FIFO empty, err_orphan 0.
- Eligibility: requester i is eligible when all three hold:
  - req_valid[i]=1;
  - ba_cmd_pm[bank_addr of req_cmd i]=1;
  - the command is a write, or the tag FIFO is not full.
- Grant:
  - Combinational search starts at pointer p and wraps modulo NUM_REQ; the first eligible requester wins.
  - req_ready[winner]=1 in the same cycle; the request is consumed at that posedge.
  - At most one grant per cycle.
- Issue registers:
  - On a grant edge: command<=req_cmd[w]; write_data<=req_wdata[w] for a write, 0 for a read; valid<=1.
  - Otherwise: valid<=0, command<=0, write_data unchanged.
  - Latency: 1 cycle from req_ready to valid.
- Pointer: after a grant to w, p<=(w+1) mod NUM_REQ. With no grant, p holds.
- Tag FIFO:
  - Each granted read pushes w; each read_data_valid pops.
  - Push and pop in the same cycle are both performed and the count is unchanged; this is legal even when the FIFO is full.
  - A full FIFO blocks read grants only; writes still proceed.
- Read return:
  - On read_data_valid with the FIFO non-empty: rd_data<=read_data and rd_valid<=onehot(head) on the next cycle, i.e. 1-cycle latency.
  - On read_data_valid with the FIFO empty: the data is dropped, rd_valid stays 0, err_orphan<=1 and remains set until reset.
- Requester obligations: req_cmd and req_wdata are held stable while req_valid=1 and not yet accepted. A requester dropping req_valid before acceptance is permitted; it is simply not granted.
- Reset mid-operation: asserting power_on_rst_n low flushes outstanding tags. Reads already in flight at the scheduler are not tracked afterwards and report err_orphan when they return.

Optional Feature:
- Macro: ARB_ROW_HIT_PRIORITY_EN.
- When defined:
  - A per-bank register holds the last issued row_addr plus a valid bit; the valid bits clear on reset.
  - Eligible requesters whose row_addr matches the open row of their bank are searched first, in round-robin order from p. Only when none match does the normal search run.
  - A starvation counter per requester saturates at 15 while the requester is eligible but not granted. At 15 it overrides row-hit priority and the counter clears on grant.
- When undefined: plain round-robin; no row registers or counters are synthesized.

Test Plan:
- All 4 requesters write bank 0 continuously, ba_cmd_pm=4'hF -> grant order 0,1,2,3,0,...; valid=1 every cycle; write_data equals the granted requester's req_wdata one cycle after its req_ready.
- Req1 reads bank 2 with ba_cmd_pm=4'b1011 -> no grant; set bit 2 -> req_ready[1] on the next cycle; command reaches the output one cycle later.
- Reads issued in order req2, req0, req3, then 3 read_data_valid pulses -> rd_valid=4'b0100, 4'b0001, 4'b1000 with matching data; rd_tag_cnt 3->0.
- Fill 16 outstanding reads; req0 read and req1 write pending -> only req1 granted. Then a read_data_valid pop in the same cycle as a push -> rd_tag_cnt stays 16.
- read_data_valid with the FIFO empty -> rd_valid stays 0, err_orphan=1 until reset. Assert reset with 5 tags outstanding -> rd_tag_cnt=0, all outputs 0.
- ARB_ROW_HIT_PRIORITY_EN: open row 0x10 in bank 0; req0 targets row 0x20, req1 row 0x10, p=0 -> req1 granted first. If req0 has been denied 15 cycles -> req0 granted.
